debounce_fsm: RTL and testbench
===============================

Name: debounce_fsm

Overview:
- Upstream conditioning stage for the switch/button edge detectors.
- Takes a raw, bouncy, asynchronous mechanical switch input and produces a clean, glitch-free level for the edge detector's `level` input.
- Also produces a one-cycle rising-edge tick, so simple consumers can bypass a separate edge detector.
- The debounce decision is made by a 4-state FSM plus a down-counter that enforces a minimum stable time.

Parameters:
- STABLE_CYCLES, 1000000: input must be stable for this many consecutive clocks before db_level changes (10 ms at 100 MHz). Legal range ≥1.
- CNT_W (localparam, not overridable): $clog2(STABLE_CYCLES+1), the down-counter width.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- sw  input  1  raw switch input; asynchronous and bouncy.
- db_level  output  1  debounced level; registered.
- db_tick  output  1  one-cycle pulse on debounced 0→1; registered.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - All state changes occur on rising clk. reset has priority over all other inputs.
- Reset values:
  - state=ZERO, cnt=0, db_level=0, db_tick=0, synchronizer flops=0 (when present).
  - Reset asserted mid-WAIT1/WAIT0 abandons the count. The first cycle after reset deasserts behaves as a fresh ZERO.
- sw_s: the sampled input used by the FSM; source depends on the Optional Feature.
- States (2-bit encoding); any unused/illegal encoding → ZERO on next edge:
  - ZERO: db_level=0.
    - sw_s=1 → WAIT1, cnt←STABLE_CYCLES-1.
  - WAIT1: db_level=0.
    - sw_s=0 → ZERO (glitch rejected).
    - Else if cnt==0 → ONE.
    - Else cnt←cnt-1.
  - ONE: db_level=1.
    - sw_s=0 → WAIT0, cnt←STABLE_CYCLES-1.
  - WAIT0: db_level=1.
    - sw_s=1 → ONE (glitch rejected).
    - Else if cnt==0 → ZERO.
    - Else cnt←cnt-1.
- db_level: registered, equals 1 exactly when state ∈ {ONE, WAIT0}.
- db_tick:
  - High for exactly one cycle: the first cycle db_level reads 1 after a WAIT1→ONE transition.
  - Never high on WAIT0→ONE (a glitch during release is not a new press).
- Latency:
  - db_level rises exactly STABLE_CYCLES+1 rising edges after the first edge at which sw_s samples 1, provided sw_s stays 1 throughout.
  - Falling is symmetric.
  - Any opposite sample inside a WAIT state restarts the full count from the next qualifying sample; there is no partial credit.
- Boundaries:
  - STABLE_CYCLES=1: WAIT state lasts one cycle; latency is 2.
  - The counter never underflows; it is loaded only on ZERO→WAIT1 and ONE→WAIT0.
- db_level and db_tick change only on clk and never glitch combinationally.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN
- Defined:
  - sw passes through a 2-flop synchronizer (reset to 0); sw_s = second flop.
  - Adds exactly 2 cycles to every latency figure above (rise and fall).
  - Required whenever sw comes from a pin.
- Undefined:
  - sw_s = sw directly, with no added latency.
  - sw must already be synchronous to clk (testbench or upstream-synchronized use only).

Test Plan (STABLE_CYCLES=4, macro undefined unless noted):
- Reset, then sw held 0 for 20 cycles → db_level=0, db_tick=0 throughout; state stays ZERO.
- sw 0→1 held high → db_level=1 on 5th edge after first high sample; db_tick=1 for that single cycle only.
- Bounce on press: sw=1,0,1,1,0,1,1,1,1,1 → db_level rises only 5 edges after the final uninterrupted run starts; exactly one db_tick.
- Release from ONE: sw=0 for 3 cycles, then 1, then 0 held → db_level stays 1 through the glitch and falls 5 edges after the final 0 run begins; no db_tick on the WAIT0→ONE return.
- reset pulsed for one cycle while in WAIT1 with sw=1 → next cycle db_level=0, state ZERO; a fresh 5-edge count is required before db_level=1.
- DEBOUNCE_SYNC_EN defined, clean sw 0→1 → db_level rises exactly 7 edges after sw changes; reset clears the synchronizer (db_level=0 for ≥7 cycles after reset even with sw=1).

Source files
------------

// File: rtl/debounce_fsm_if.sv
// Switch-side signal bundle for the debouncer: raw switch in, clean level and press tick out.
interface debounce_fsm_if;
    logic sw;
    logic db_level;
    logic db_tick;

    modport master (output sw, input db_level, input db_tick);
    modport slave  (input sw, output db_level, output db_tick);
endinterface

// File: rtl/debounce_fsm.sv
// Switch debouncer: 4-state FSM plus a stability down-counter, registered level and press tick.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer on sw (adds 2 cycles of latency).
module debounce_fsm #(
    parameter int STABLE_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    debounce_fsm_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sw_s;
    logic             level_q, tick_q;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], bus.sw};
    end

    assign sw_s = sync_q[1];
`else
    assign sw_s = bus.sw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ZERO;
            cnt     <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            level_q <= (state_n == ONE) || (state_n == WAIT0);
            // Only a qualified press counts; a WAIT0->ONE return is a rejected release glitch.
            tick_q  <= (state == WAIT1) && (state_n == ONE);
        end
    end

    // Counter is loaded only when entering a WAIT state, so it cannot underflow.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ZERO: begin
                if (sw_s) begin
                    state_n = WAIT1;
                    cnt_n   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s)           state_n = ZERO;
                else if (cnt == '0)  state_n = ONE;
                else                 cnt_n   = cnt - 1'b1;
            end
            ONE: begin
                if (!sw_s) begin
                    state_n = WAIT0;
                    cnt_n   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s)            state_n = ONE;
                else if (cnt == '0)  state_n = ZERO;
                else                 cnt_n   = cnt - 1'b1;
            end
            default: state_n = ZERO;
        endcase
    end

    assign bus.db_level = level_q;
    assign bus.db_tick  = tick_q;
endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with STABLE_CYCLES=4, plus a STABLE_CYCLES=1 boundary instance.
module tb_debounce_fsm;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    debounce_fsm_if dif ();
    debounce_fsm_if dif1 ();

    debounce_fsm #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    debounce_fsm #(.STABLE_CYCLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (dif1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Drive sw on both instances, advance one edge, sample 1 ns later.
    task automatic step(input logic v);
        dif.sw  = v;
        dif1.sw = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic pat [10];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        reset   = 1'b1;
        dif.sw  = 1'b0;
        dif1.sw = 1'b0;
        step(1'b0);
        step(1'b0);
        chk("reset_level", dif.db_level, 1'b0);
        chk("reset_tick",  dif.db_tick,  1'b0);
        reset = 1'b0;

`ifdef DEBOUNCE_SYNC_EN
        for (int i = 0; i < 5; i++) step(1'b0);
        // Clean press: sync adds 2 edges, level rises on the 7th edge.
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            chk($sformatf("sync_press_lvl_e%0d", i), dif.db_level, (i == 7));
            chk($sformatf("sync_press_tick_e%0d", i), dif.db_tick, (i == 7));
        end
        step(1'b1);
        chk("sync_tick_clear", dif.db_tick, 1'b0);
        // Reset must clear synchronizer and FSM even with sw held high.
        reset = 1'b1;
        step(1'b1);
        chk("sync_rst_level", dif.db_level, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            chk($sformatf("sync_after_rst_e%0d", i), dif.db_level, (i == 7));
        end
`else
        // Idle low: nothing moves.
        for (int i = 0; i < 20; i++) begin
            step(1'b0);
            chk($sformatf("idle_lvl_%0d", i), dif.db_level, 1'b0);
            chk($sformatf("idle_tick_%0d", i), dif.db_tick, 1'b0);
        end

        // Clean press: level and tick on the 5th edge.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1);
            chk($sformatf("press_lvl_e%0d", i), dif.db_level, (i == 5));
            chk($sformatf("press_tick_e%0d", i), dif.db_tick, (i == 5));
        end
        step(1'b1);
        chk("press_hold_lvl",  dif.db_level, 1'b1);
        chk("press_tick_once", dif.db_tick,  1'b0);

        // Clean release back to ZERO.
        for (int i = 1; i <= 5; i++) begin
            step(1'b0);
            chk($sformatf("rel_lvl_e%0d", i), dif.db_level, (i != 5));
            chk($sformatf("rel_tick_e%0d", i), dif.db_tick, 1'b0);
        end

        // Bouncy press: last uninterrupted run starts at step 6, rises at step 10.
        for (int i = 0; i < 10; i++) begin
            step(pat[i]);
            chk($sformatf("bounce_lvl_%0d", i), dif.db_level, (i == 9));
            chk($sformatf("bounce_tick_%0d", i), dif.db_tick, (i == 9));
        end

        // Release glitch: 0,0,0,1 then 0 held; falls on the 5th edge of the final run.
        for (int i = 1; i <= 3; i++) begin
            step(1'b0);
            chk($sformatf("relg_lvl_%0d", i), dif.db_level, 1'b1);
            chk($sformatf("relg_tick_%0d", i), dif.db_tick, 1'b0);
        end
        step(1'b1);
        chk("relg_return_lvl",  dif.db_level, 1'b1);
        chk("relg_return_tick", dif.db_tick,  1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0);
            chk($sformatf("relg_fall_lvl_e%0d", i), dif.db_level, (i != 5));
            chk($sformatf("relg_fall_tick_e%0d", i), dif.db_tick, 1'b0);
        end

        // Reset inside WAIT1 abandons the count.
        step(1'b1);
        step(1'b1);
        reset = 1'b1;
        step(1'b1);
        chk("rst_wait1_lvl",  dif.db_level, 1'b0);
        chk("rst_wait1_tick", dif.db_tick,  1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1);
            chk($sformatf("rst_fresh_lvl_e%0d", i), dif.db_level, (i == 5));
            chk($sformatf("rst_fresh_tick_e%0d", i), dif.db_tick, (i == 5));
        end

        // STABLE_CYCLES=1 boundary: latency 2 both ways, single-sample glitch rejected.
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        step(1'b1);
        chk("sc1_rise_e1", dif1.db_level, 1'b0);
        step(1'b1);
        chk("sc1_rise_e2",  dif1.db_level, 1'b1);
        chk("sc1_rise_tick", dif1.db_tick, 1'b1);
        step(1'b0);
        chk("sc1_fall_e1", dif1.db_level, 1'b1);
        step(1'b0);
        chk("sc1_fall_e2", dif1.db_level, 1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        chk("sc1_glitch_lvl",  dif1.db_level, 1'b0);
        chk("sc1_glitch_tick", dif1.db_tick,  1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
